// File: rtl/matrix_tile_loader.sv
// Double-buffered serial-to-tile packer: gathers N*L row-major W-bit elements
// into one packed tile and hands it to the matmul stage over valid/ready.
module matrix_tile_loader #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 3,
  parameter int unsigned L = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N*L*W-1:0] m_mtx,
  output logic             err
);

  localparam int unsigned NL = N * L;
  localparam int unsigned TW = NL * W;
  localparam int unsigned IW = (NL > 1) ? $clog2(NL) : 1;

  logic [1:0][TW-1:0] tile_buf;
  logic               wr_sel;
  logic               rd_sel;
  logic [1:0]         count;
  logic [IW-1:0]      idx;

  logic accept;
  logic last_k;
  logic complete;
  logic frame_err;
  logic take;

  // Handshake and framing decode, all from registered state plus inputs.
  assign s_ready   = (count != 2'd2);
  assign m_valid   = (count != 2'd0);
  assign m_mtx     = tile_buf[rd_sel];
  assign accept    = s_valid && s_ready;
  assign last_k    = (idx == IW'(NL - 1));
  assign complete  = accept && s_last && last_k;
  assign frame_err = accept && (s_last != last_k);
  assign take      = m_valid && m_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tile_buf <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      count    <= 2'd0;
      idx      <= '0;
      err      <= 1'b0;
    end else if (flush) begin
      // Flush wins over any same-cycle accept or transfer.
      tile_buf <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      count    <= 2'd0;
      idx      <= '0;
      err      <= 1'b0;
    end else begin
      err <= frame_err;
      if (accept) begin
        tile_buf[wr_sel][32'(idx) * W +: W] <= s_data;
        idx <= (last_k || s_last) ? '0 : idx + IW'(1);
      end
      if (complete) wr_sel <= ~wr_sel;
      if (take)     rd_sel <= ~rd_sel;
      // Completion and transfer in the same cycle leave the fill level unchanged.
      case ({complete, take})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_tile_loader.sv
// Directed bench for matrix_tile_loader: framing, backpressure, streaming, reset and flush.
module tb_matrix_tile_loader;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 3;
  localparam int unsigned L  = 3;
  localparam int unsigned TW = N * L * W;

  logic          clk;
  logic          rstn;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [TW-1:0] m_mtx;
  logic          err;

  int errors = 0;
  int checks = 0;
  int delivered = 0;

  matrix_tile_loader #(.W(W), .N(N), .L(L)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_mtx(m_mtx), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected tile: element k (value base+k) sits at bits [k*8 +: 8].
  function automatic logic [TW-1:0] tile(input int base);
    logic [TW-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'(base + k);
    return r;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkm(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input logic last);
    s_valid = 1'b1;
    s_data  = 8'(d);
    s_last  = last;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic push_tile(input int base);
    for (int k = 0; k < 9; k++) push(base + k, k == 8);
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_s_ready", s_ready, 1'b1);
    check1("rst_m_valid", m_valid, 1'b0);
    checkm("rst_m_mtx", m_mtx, '0);
    check1("rst_err", err, 1'b0);
    rstn = 1'b1;
    idle();

    // 1: single tile, consumer ready
    m_ready = 1'b1;
    for (int k = 1; k <= 8; k++) push(k, 1'b0);
    check1("t1_no_valid_before_last", m_valid, 1'b0);
    push(9, 1'b1);
    check1("t1_valid_after_last", m_valid, 1'b1);
    checkm("t1_mtx", m_mtx, 72'h090807060504030201);
    check1("t1_err", err, 1'b0);
    idle();
    check1("t1_drained", m_valid, 1'b0);

    // 2: backpressure with tiles A, B, C
    m_ready = 1'b0;
    push_tile(1);
    check1("t2_a_valid", m_valid, 1'b1);
    check1("t2_a_ready", s_ready, 1'b1);
    push_tile(11);
    check1("t2_full_ready_low", s_ready, 1'b0);
    checkm("t2_hold_a", m_mtx, tile(1));
    s_valid = 1'b1; s_data = 8'd21; s_last = 1'b0;
    idle();
    idle();
    check1("t2_stall_ready_low", s_ready, 1'b0);
    checkm("t2_stall_hold_a", m_mtx, tile(1));
    s_valid = 1'b0;
    m_ready = 1'b1;
    idle();
    m_ready = 1'b0;
    checkm("t2_b_presented", m_mtx, tile(11));
    check1("t2_b_valid", m_valid, 1'b1);
    check1("t2_ready_back", s_ready, 1'b1);
    push_tile(21);
    check1("t2_full_again", s_ready, 1'b0);
    m_ready = 1'b1;
    idle();
    checkm("t2_c_presented", m_mtx, tile(21));
    idle();
    check1("t2_empty", m_valid, 1'b0);

    // 3: early s_last on the 4th element
    push(1, 1'b0); push(2, 1'b0); push(3, 1'b0); push(4, 1'b1);
    check1("t3_err_pulse", err, 1'b1);
    check1("t3_no_valid", m_valid, 1'b0);
    idle();
    check1("t3_err_clear", err, 1'b0);
    push_tile(1);
    checkm("t3_clean_tile", m_mtx, tile(1));
    check1("t3_clean_valid", m_valid, 1'b1);
    idle();

    // 4: ninth element without s_last
    for (int k = 1; k <= 9; k++) push(k, 1'b0);
    check1("t4_err_pulse", err, 1'b1);
    check1("t4_no_valid", m_valid, 1'b0);
    idle();
    check1("t4_err_clear", err, 1'b0);
    check1("t4_count_zero", m_valid, 1'b0);
    push_tile(11);
    checkm("t4_next_tile", m_mtx, tile(11));
    idle();

    // 5: continuous stream of four tiles
    delivered = 0;
    for (int e = 0; e < 36; e++) begin
      push(40 + 10 * (e / 9) + (e % 9), (e % 9) == 8);
      check1("t5_s_ready", s_ready, 1'b1);
      if (m_valid) begin
        checkm("t5_tile", m_mtx, tile(40 + 10 * delivered));
        delivered++;
      end
    end
    idle();
    check1("t5_drained", m_valid, 1'b0);
    checkm("t5_delivered", 72'(delivered), 72'd4);

    // 6: reset mid-tile, then flush with one tile pending
    m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push(k, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check1("t6_rst_s_ready", s_ready, 1'b1);
    check1("t6_rst_m_valid", m_valid, 1'b0);
    checkm("t6_rst_m_mtx", m_mtx, '0);
    check1("t6_rst_err", err, 1'b0);
    rstn = 1'b1;
    idle();
    check1("t6_no_err_after_rst", err, 1'b0);
    push_tile(1);
    checkm("t6_after_rst_tile", m_mtx, tile(1));
    check1("t6_pending", m_valid, 1'b1);
    flush = 1'b1;
    s_valid = 1'b1; s_data = 8'd99; s_last = 1'b0;
    idle();
    flush = 1'b0;
    s_valid = 1'b0;
    check1("t6_flush_m_valid", m_valid, 1'b0);
    check1("t6_flush_s_ready", s_ready, 1'b1);
    check1("t6_flush_err", err, 1'b0);
    push_tile(61);
    checkm("t6_flush_next_tile", m_mtx, tile(61));
    check1("t6_flush_next_valid", m_valid, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
